weight_scheduler: RTL and testbench
===================================

WEIGHT_SCHEDULER -- requirements
Module: weight_scheduler

Interface
REQ-001 Parameter NUM_FILTERS, default 3, number of per-filter weight banks sequenced.
REQ-002 Parameter INPUT_CHANNELS, default 3, channels per filter.
REQ-003 Parameter KERNEL_SIZE, default 3, kernel edge length.
REQ-004 Parameter WEIGHT_WIDTH, default 8, bits per weight.
REQ-005 Parameter TIMEOUT_CYCLES, default 100, maximum wait for bank weight_valid.
REQ-006 Derived constant WBUS = INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH, default 216.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  begin one pass over all filters; sampled only in IDLE.
REQ-010 busy  output  1  high in any state except IDLE and ERR.
REQ-011 done  output  1  one-cycle pulse after last filter accepted.
REQ-012 timeout_err  output  1  sticky error flag.
REQ-013 bank_read_enable  output  NUM_FILTERS  one-hot read_enable to weight bank i.
REQ-014 bank_weight_valid  input  NUM_FILTERS  weight_valid from bank i.
REQ-015 bank_weight_data  input  NUM_FILTERS*WBUS  bank i's multi_channel_weight_out at slice [i*WBUS +: WBUS].
REQ-016 w_data  output  WBUS  captured weights for the current filter.
REQ-017 w_filter_id  output  clog2(NUM_FILTERS), min 1  index of filter on w_data.
REQ-018 w_valid  output  1  w_data/w_filter_id valid.
REQ-019 w_ready  input  1  downstream accept; transfer when w_valid && w_ready.

Function
REQ-020 FSM states are IDLE, REQ, PRESENT, DONE and ERR.
REQ-021 In IDLE, start=1 → REQ, idx=0, wait counter=0, timeout_err cleared.
REQ-022 In REQ, bank_read_enable = (1<<idx) and all other bits are 0.
REQ-023 In any state other than REQ, bank_read_enable = 0.
REQ-024 In REQ, on an edge with bank_weight_valid[idx]=1, capture slice idx into w_data, set w_filter_id=idx, and go to PRESENT.
REQ-025 w_valid rises the cycle after capture (capture latency 1 cycle).
REQ-026 bank_weight_valid bits other than idx are ignored.
REQ-027 In REQ, the wait counter increments each cycle without valid.
REQ-028 In REQ, counter reaching TIMEOUT_CYCLES-1 without valid → ERR, timeout_err=1.
REQ-029 If valid and the timeout coincide on the same edge, valid wins.
REQ-030 In PRESENT, w_valid=1, and w_data/w_filter_id stay stable until a transfer.
REQ-031 On transfer with idx<NUM_FILTERS-1: idx+1, counter=0, go to REQ, w_valid=0 next cycle.
REQ-032 On transfer with idx=NUM_FILTERS-1: go to DONE.
REQ-033 DONE asserts done for exactly 1 cycle, then → IDLE; w_data holds its last value.
REQ-034 In ERR, timeout_err stays 1 and busy=0; start → REQ idx=0 and clears timeout_err.
REQ-035 start while busy is ignored, with no restart and no queueing.
REQ-036 NUM_FILTERS=1 is legal: REQ → PRESENT → DONE.

Reset
REQ-037 rst_n low at any time, including mid-pass, forces IDLE.
REQ-038 Reset clears idx, counter, w_data, w_filter_id, w_valid, done, busy, timeout_err and bank_read_enable to 0 immediately, without waiting for clk.
REQ-039 After reset release, no activity occurs until a new start.

Structure
REQ-040 Shared package cnn_pkg holds the FSM state enum, the WBUS width function and the clog2-based index width helper.
REQ-041 The wait counter is one sub-module, wait_timer (clear, enable, expired), reusable by other CNN controllers.

Verification
REQ-042 Reset → start; 3 banks assert valid 2 cycles after read_enable; w_ready=1. Required: w_filter_id 0,1,2 in order; done pulses once; filter 0 slice, every channel = FF 00 01 FE 00 02 FF 00 01.
REQ-043 w_ready=0 for 5 cycles on filter 1. Required: w_valid held; w_data/w_filter_id=1 stable; bank_read_enable=0 throughout.
REQ-044 Bank 2 never asserts valid, TIMEOUT_CYCLES=100. Required: ERR after 100 REQ cycles; timeout_err=1; busy=0; next start clears timeout_err and restarts at idx 0.
REQ-045 rst_n low during REQ of filter 1. Required: all outputs 0 asynchronously; after release, no bank_read_enable until start.
REQ-046 start pulsed during PRESENT, and valid on a non-selected bank during REQ. Required: both ignored; sequence unchanged; exactly one done.
REQ-047 Assertion throughout every scenario: bank_read_enable is always one-hot or zero.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and width helpers for the CNN controller blocks.
package cnn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_PRESENT,
      ST_DONE,
      ST_ERR
   } sched_state_t;

   function automatic int wbus_width(input int channels, input int kernel, input int width);
      return channels * kernel * kernel * width;
   endfunction

   // Index fields keep at least one bit so a single-filter build still has a port.
   function automatic int index_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter: clear wins over enable, expired flags LIMIT-1 reached.
module wait_timer #(
   parameter int LIMIT = 100
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count;

   assign expired = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/weight_scheduler.sv
// Sequences one weight fetch per filter bank and presents each filter's
// weights downstream with a valid/ready handshake and a request timeout.
module weight_scheduler
   import cnn_pkg::*;
#(
   parameter int  NUM_FILTERS    = 3,
   parameter int  INPUT_CHANNELS = 3,
   parameter int  KERNEL_SIZE    = 3,
   parameter int  WEIGHT_WIDTH   = 8,
   parameter int  TIMEOUT_CYCLES = 100,
   localparam int WBUS           = wbus_width(INPUT_CHANNELS, KERNEL_SIZE, WEIGHT_WIDTH),
   localparam int IDXW           = index_width(NUM_FILTERS)
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout_err,
   output logic [NUM_FILTERS-1:0]      bank_read_enable,
   input  logic [NUM_FILTERS-1:0]      bank_weight_valid,
   input  logic [NUM_FILTERS*WBUS-1:0] bank_weight_data,
   output logic [WBUS-1:0]             w_data,
   output logic [IDXW-1:0]             w_filter_id,
   output logic                        w_valid,
   input  logic                        w_ready
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_FILTERS - 1);

   sched_state_t    state;
   sched_state_t    next_state;
   logic [IDXW-1:0] idx;
   logic            sel_valid;
   logic            timer_clear;
   logic            timer_enable;
   logic            timer_expired;
   logic            start_pass;
   logic            capture;
   logic            advance;
   logic            set_err;

   // Only the currently requested bank's valid matters.
   assign sel_valid = bank_weight_valid[idx];

   wait_timer #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The timer is held clear outside REQ so every request starts counting from zero.
   always_comb begin
      next_state   = state;
      start_pass   = 1'b0;
      capture      = 1'b0;
      advance      = 1'b0;
      set_err      = 1'b0;
      timer_clear  = 1'b1;
      timer_enable = 1'b0;
      case (state)
         ST_IDLE, ST_ERR: begin
            if (start) begin
               next_state = ST_REQ;
               start_pass = 1'b1;
            end
         end
         ST_REQ: begin
            timer_clear = 1'b0;
            if (sel_valid) begin
               next_state = ST_PRESENT;
               capture    = 1'b1;
            end else if (timer_expired) begin
               next_state = ST_ERR;
               set_err    = 1'b1;
            end else begin
               timer_enable = 1'b1;
            end
         end
         ST_PRESENT: begin
            if (w_ready) begin
               if (idx == LAST_IDX) begin
                  next_state = ST_DONE;
               end else begin
                  next_state = ST_REQ;
                  advance    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (start_pass) begin
         idx <= '0;
      end else if (advance) begin
         idx <= idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err <= 1'b0;
      end else if (start_pass) begin
         timeout_err <= 1'b0;
      end else if (set_err) begin
         timeout_err <= 1'b1;
      end
   end

   // w_data keeps the last captured filter after the pass completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_data      <= '0;
         w_filter_id <= '0;
      end else if (capture) begin
         w_data      <= bank_weight_data[idx*WBUS +: WBUS];
         w_filter_id <= idx;
      end
   end

   always_comb begin
      bank_read_enable = '0;
      if (state == ST_REQ) begin
         bank_read_enable[idx] = 1'b1;
      end
   end

   assign busy    = (state == ST_REQ) || (state == ST_PRESENT) || (state == ST_DONE);
   assign w_valid = (state == ST_PRESENT);
   assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_weight_scheduler.sv
// Directed bench for weight_scheduler with a three-bank valid-after-two-cycles model.
module tb_weight_scheduler;

   localparam int NF = 3;
   localparam int WB = 216;
   localparam logic [71:0] CH0 = 72'h01_00_FF_02_00_FE_01_00_FF;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           busy;
   logic           done;
   logic           timeout_err;
   logic [NF-1:0]  bank_read_enable;
   logic [NF-1:0]  bank_weight_valid;
   logic [NF*WB-1:0] bank_weight_data;
   logic [WB-1:0]  w_data;
   logic [1:0]     w_filter_id;
   logic           w_valid;
   logic           w_ready;

   int checks = 0;
   int errors = 0;

   logic [WB-1:0] bank_data [NF];
   logic [NF-1:0] bank_alive;
   logic [NF-1:0] extra_valid;
   int            re_cnt [NF];

   int            n_xfer;
   int            n_done;
   int            req0_cycles;
   int            req_wrong;
   int            stall_seen;
   int            stall_bad;
   int            timed_out;
   logic [1:0]    got_id [8];
   logic [WB-1:0] got_data [8];

   weight_scheduler #(
      .NUM_FILTERS    (3),
      .INPUT_CHANNELS (3),
      .KERNEL_SIZE    (3),
      .WEIGHT_WIDTH   (8),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .busy              (busy),
      .done              (done),
      .timeout_err       (timeout_err),
      .bank_read_enable  (bank_read_enable),
      .bank_weight_valid (bank_weight_valid),
      .bank_weight_data  (bank_weight_data),
      .w_data            (w_data),
      .w_filter_id       (w_filter_id),
      .w_valid           (w_valid),
      .w_ready           (w_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bank_weight_data = {bank_data[2], bank_data[1], bank_data[0]};

   // Each bank raises valid once its read_enable has been high for two edges.
   always @(posedge clk) begin
      for (int i = 0; i < NF; i++) begin
         re_cnt[i] <= bank_read_enable[i] ? re_cnt[i] + 1 : 0;
      end
   end

   always_comb begin
      for (int i = 0; i < NF; i++) begin
         bank_weight_valid[i] = (bank_alive[i] && (re_cnt[i] >= 2)) || extra_valid[i];
      end
   end

   always @(negedge clk) begin
      checks++;
      if (!$onehot0(bank_read_enable)) begin
         errors++;
         $display("[TB] FAIL onehot_read_enable: got %b expected one-hot or zero", bank_read_enable);
      end
   end

   initial begin
      #400000;
      errors++;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Runs one pass; optionally stalls one filter, pokes start during the stall
   // and glitches non-selected valids during the first request.
   task automatic run_pass(input int stall_id, input int stall_len, input bit poke_start,
                           input logic [NF-1:0] glitch);
      int            stall_cnt;
      logic [WB-1:0] snap_data;
      logic [1:0]    snap_id;
      bit            finished;
      n_xfer = 0; n_done = 0; req0_cycles = 0; req_wrong = 0;
      stall_seen = 0; stall_bad = 0; timed_out = 1; stall_cnt = 0; finished = 0;
      snap_data = '0; snap_id = '0;
      w_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      extra_valid = glitch;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         start = 1'b0;
         if (w_valid) extra_valid = '0;
         if (busy && !w_valid && !done) begin
            if (bank_read_enable !== (3'(1) << n_xfer)) req_wrong++;
            if (n_xfer == 0) req0_cycles++;
         end
         if (w_valid && (w_filter_id == 2'(stall_id)) && (stall_cnt < stall_len)) begin
            w_ready = 1'b0;
            if (stall_cnt == 0) begin
               snap_data = w_data;
               snap_id   = w_filter_id;
            end else if ((w_data !== snap_data) || (w_filter_id !== snap_id)) begin
               stall_bad++;
            end
            if (bank_read_enable !== '0) stall_bad++;
            if (poke_start && (stall_cnt == 1)) start = 1'b1;
            stall_cnt++;
            stall_seen++;
         end else if (w_valid) begin
            w_ready = 1'b1;
            if (n_xfer < 8) begin
               got_id[n_xfer]   = w_filter_id;
               got_data[n_xfer] = w_data;
            end
            n_xfer++;
         end else begin
            w_ready = 1'b1;
         end
         if (done) n_done++;
         if ((n_done > 0) && !done) begin
            finished  = 1;
            timed_out = 0;
         end else begin
            @(negedge clk);
         end
      end
      start = 1'b0;
      w_ready = 1'b1;
      extra_valid = '0;
   endtask

   task automatic test_reset();
      int activity;
      rst_n = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      checks++; if (bank_read_enable !== 3'b000) begin errors++; $display("[TB] FAIL reset_read_enable: got %b expected 000", bank_read_enable); end
      checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_valid: got %b expected 0", w_valid); end
      checks++; if (w_data !== '0) begin errors++; $display("[TB] FAIL reset_w_data: got %h expected 0", w_data); end
      checks++; if (w_filter_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_w_filter_id: got %0d expected 0", w_filter_id); end
      start = 1'b0;
      rst_n = 1'b1;
      activity = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy || (bank_read_enable !== 3'b000)) activity++;
      end
      checks++; if (activity !== 0) begin errors++; $display("[TB] FAIL reset_idle_after_release: got %0d active cycles expected 0", activity); end
   endtask

   task automatic test_normal_pass();
      run_pass(-1, 0, 1'b0, 3'b000);
      checks++; if (timed_out !== 0) begin errors++; $display("[TB] FAIL normal_timed_out: got %0d expected 0", timed_out); end
      checks++; if (n_xfer !== 3) begin errors++; $display("[TB] FAIL normal_xfer_count: got %0d expected 3", n_xfer); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_id[i] !== 2'(i)) begin errors++; $display("[TB] FAIL normal_filter_id[%0d]: got %0d expected %0d", i, got_id[i], i); end
      end
      checks++; if (got_data[0] !== {3{CH0}}) begin errors++; $display("[TB] FAIL normal_filter0_data: got %h expected %h", got_data[0], {3{CH0}}); end
      checks++; if (got_data[1] !== bank_data[1]) begin errors++; $display("[TB] FAIL normal_filter1_data: got %h expected %h", got_data[1], bank_data[1]); end
      checks++; if (got_data[2] !== bank_data[2]) begin errors++; $display("[TB] FAIL normal_filter2_data: got %h expected %h", got_data[2], bank_data[2]); end
      checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL normal_done_pulses: got %0d expected 1", n_done); end
      checks++; if (req_wrong !== 0) begin errors++; $display("[TB] FAIL normal_read_enable_select: got %0d bad cycles expected 0", req_wrong); end
      checks++; if (req0_cycles !== 3) begin errors++; $display("[TB] FAIL normal_req0_latency: got %0d cycles expected 3", req0_cycles); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL normal_busy_after_done: got %b expected 0", busy); end
      checks++; if (w_data !== bank_data[2]) begin errors++; $display("[TB] FAIL normal_w_data_hold: got %h expected %h", w_data, bank_data[2]); end
   endtask

   task automatic test_backpressure();
      run_pass(1, 5, 1'b0, 3'b000);
      checks++; if (stall_seen !== 5) begin errors++; $display("[TB] FAIL stall_valid_held: got %0d cycles expected 5", stall_seen); end
      checks++; if (stall_bad !== 0) begin errors++; $display("[TB] FAIL stall_stability: got %0d bad cycles expected 0", stall_bad); end
      checks++; if (n_xfer !== 3) begin errors++; $display("[TB] FAIL stall_xfer_count: got %0d expected 3", n_xfer); end
      checks++; if (got_id[1] !== 2'd1) begin errors++; $display("[TB] FAIL stall_filter_id: got %0d expected 1", got_id[1]); end
      checks++; if (got_data[1] !== bank_data[1]) begin errors++; $display("[TB] FAIL stall_filter1_data: got %h expected %h", got_data[1], bank_data[1]); end
      checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL stall_done_pulses: got %0d expected 1", n_done); end
   endtask

   task automatic test_timeout();
      int req2;
      bit seen_err;
      bit seen_done;
      bank_alive = 3'b011;
      w_ready = 1'b1;
      req2 = 0;
      seen_err = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 400 && !seen_err; cyc++) begin
         if (bank_read_enable == 3'b100) req2++;
         if (timeout_err) seen_err = 1;
         else @(negedge clk);
      end
      checks++; if (seen_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: got %b expected 1", seen_err); end
      checks++; if (req2 !== 100) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 100", req2); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: got %b expected 0", busy); end
      checks++; if (bank_read_enable !== 3'b000) begin errors++; $display("[TB] FAIL timeout_read_enable: got %b expected 000", bank_read_enable); end
      repeat (3) @(negedge clk);
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err); end
      bank_alive = 3'b111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_cleared_on_start: got %b expected 0", timeout_err); end
      checks++; if (bank_read_enable !== 3'b001) begin errors++; $display("[TB] FAIL timeout_restart_idx0: got %b expected 001", bank_read_enable); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_restart_busy: got %b expected 1", busy); end
      seen_done = 0;
      for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      checks++; if (seen_done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_recovery_done: got %b expected 1", seen_done); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit found;
      int activity;
      found = 0;
      w_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 50 && !found; cyc++) begin
         if (bank_read_enable == 3'b010) found = 1;
         else @(negedge clk);
      end
      checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL midreset_reached_filter1: got %b expected 1", found); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
      checks++; if (bank_read_enable !== 3'b000) begin errors++; $display("[TB] FAIL midreset_read_enable: got %b expected 000", bank_read_enable); end
      checks++; if (w_data !== '0) begin errors++; $display("[TB] FAIL midreset_w_data: got %h expected 0", w_data); end
      checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_w_valid: got %b expected 0", w_valid); end
      checks++; if (w_filter_id !== 2'd0) begin errors++; $display("[TB] FAIL midreset_w_filter_id: got %0d expected 0", w_filter_id); end
      checks++; if ((done !== 1'b0) || (timeout_err !== 1'b0)) begin errors++; $display("[TB] FAIL midreset_flags: got done=%b timeout_err=%b expected 0 0", done, timeout_err); end
      @(negedge clk);
      rst_n = 1'b1;
      activity = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy || (bank_read_enable !== 3'b000)) activity++;
      end
      checks++; if (activity !== 0) begin errors++; $display("[TB] FAIL midreset_idle_after_release: got %0d active cycles expected 0", activity); end
   endtask

   task automatic test_ignore();
      int activity;
      run_pass(0, 3, 1'b1, 3'b110);
      checks++; if (n_xfer !== 3) begin errors++; $display("[TB] FAIL ignore_xfer_count: got %0d expected 3", n_xfer); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_id[i] !== 2'(i)) begin errors++; $display("[TB] FAIL ignore_filter_id[%0d]: got %0d expected %0d", i, got_id[i], i); end
      end
      checks++; if (got_data[0] !== {3{CH0}}) begin errors++; $display("[TB] FAIL ignore_filter0_data: got %h expected %h", got_data[0], {3{CH0}}); end
      checks++; if (req0_cycles !== 3) begin errors++; $display("[TB] FAIL ignore_req0_latency: got %0d cycles expected 3", req0_cycles); end
      checks++; if (req_wrong !== 0) begin errors++; $display("[TB] FAIL ignore_read_enable_select: got %0d bad cycles expected 0", req_wrong); end
      checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL ignore_done_pulses: got %0d expected 1", n_done); end
      activity = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy || done) activity++;
      end
      checks++; if (activity !== 0) begin errors++; $display("[TB] FAIL ignore_no_queued_start: got %0d active cycles expected 0", activity); end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      w_ready = 1'b1;
      bank_alive = 3'b111;
      extra_valid = 3'b000;
      bank_data[0] = {3{CH0}};
      bank_data[1] = {3{72'h09_08_07_06_05_04_03_02_01}};
      bank_data[2] = {72'hC3_C2_C1_C0_BF_BE_BD_BC_BB,
                      72'hB2_B1_B0_AF_AE_AD_AC_AB_AA,
                      72'hA1_A0_9F_9E_9D_9C_9B_9A_99};
      $display("[TB] starting weight_scheduler bench");
      test_reset();
      test_normal_pass();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_ignore();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
